// File: rtl/systolic_mm_pkg.sv
// Shared types and bus-packing helpers for the 3x3 systolic MAC array sequencer.
package systolic_mm_pkg;

   localparam int N      = 3;
   localparam int DATA_W = 32;
   localparam int ACC_W  = 64;
   localparam int BUS_W  = N * DATA_W;
   localparam int RES_W  = N * N * ACC_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_HOLD  = 3'd4
   } state_e;

   // Lane i of a flat operand bus occupies bits [32i+31:32i].
   function automatic logic [DATA_W-1:0] get_lane(input logic [BUS_W-1:0] bus, input int i);
      return bus[DATA_W*i +: DATA_W];
   endfunction

   // Accumulator (row i, col j) sits at entry i*N+j of the flat result bus.
   function automatic logic [ACC_W-1:0] get_acc(input logic [RES_W-1:0] bus, input int i,
                                                input int j);
      return bus[ACC_W*(N*i+j) +: ACC_W];
   endfunction

endpackage

// File: rtl/systolic_mm_drain_cnt.sv
// Loadable down-counter with a zero flag; times the array drain window.
module systolic_mm_drain_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/systolic_mm_ctrl.sv
// Job sequencer for the 3x3 systolic array: clear, feed K operand beats, drain,
// capture the nine accumulators and hold them until the consumer takes them.
module systolic_mm_ctrl
   import systolic_mm_pkg::*;
#(
   parameter int SKEW    = 4,
   parameter int MAC_LAT = 1,
   parameter int KW      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KW-1:0]     k_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BUS_W-1:0]  in_a,
   input  logic [BUS_W-1:0]  in_b,
   output logic [BUS_W-1:0]  arr_a,
   output logic [BUS_W-1:0]  arr_b,
   output logic              mac_clr,
   input  logic [RES_W-1:0]  res_in,
   output logic [RES_W-1:0]  res_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [31:0]       last_cycles
);

   // Operand register + skew to the far corner MAC + MAC latency.
   localparam int DRAIN_LEN = SKEW + MAC_LAT + 1;
   localparam int CW        = $clog2(DRAIN_LEN + 1);

   state_e        state, state_n;
   logic [KW-1:0] k_reg;
   logic [KW-1:0] beat_cnt;
   logic [31:0]   cyc_cnt;
   logic [31:0]   cyc_inc;
   logic          beat_acc;
   logic          drain_load;
   logic          drain_zero;

   systolic_mm_drain_cnt #(
      .W(CW)
   ) u_drain_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (drain_load),
      .load_val (CW'(DRAIN_LEN - 1)),
      .dec      (state == S_DRAIN),
      .zero     (drain_zero)
   );

   assign in_ready  = (state == S_FEED) && (beat_cnt < k_reg);
   assign beat_acc  = in_valid && in_ready;
   assign mac_clr   = (state == S_CLEAR);
   assign out_valid = (state == S_HOLD);
   assign busy      = (state != S_IDLE);
   assign cyc_inc   = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n    = state;
      drain_load = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_n = S_CLEAR;
         end
         S_CLEAR: begin
            if (k_reg != '0) begin
               state_n = S_FEED;
            end else begin
               state_n    = S_DRAIN;
               drain_load = 1'b1;
            end
         end
         S_FEED: begin
            if (beat_acc && (beat_cnt == k_reg - 1'b1)) begin
               state_n    = S_DRAIN;
               drain_load = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_zero) state_n = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         k_reg       <= '0;
         beat_cnt    <= '0;
         cyc_cnt     <= '0;
         arr_a       <= '0;
         arr_b       <= '0;
         res_out     <= '0;
         last_cycles <= '0;
      end else begin
         state <= state_n;
         // Idle and stalled cycles push zero bubbles, which add nothing to the MACs.
         arr_a <= beat_acc ? in_a : '0;
         arr_b <= beat_acc ? in_b : '0;

         if ((state == S_IDLE) && start) begin
            k_reg    <= k_len;
            beat_cnt <= '0;
            cyc_cnt  <= '0;
         end else if (state inside {S_CLEAR, S_FEED, S_DRAIN}) begin
            cyc_cnt <= cyc_inc;
         end

         if (beat_acc) beat_cnt <= beat_cnt + 1'b1;

         if ((state == S_DRAIN) && drain_zero) begin
            res_out     <= res_in;
            last_cycles <= cyc_inc;
         end
      end
   end

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Scoreboard bench for systolic_mm_ctrl with a behavioural skewed 3x3 MAC array model.
module tb_systolic_mm_ctrl;
   import systolic_mm_pkg::*;

   localparam int KW = 16;

   typedef logic [63:0] res9_t [9];
   typedef struct {
      logic [575:0] res;
      logic [31:0]  cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_len;
   logic          in_valid;
   logic          in_ready;
   logic [95:0]   in_a, in_b;
   logic [95:0]   arr_a, arr_b;
   logic          mac_clr;
   logic [575:0]  res_in;
   logic [575:0]  res_out;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic [31:0]   last_cycles;

   systolic_mm_ctrl #(.SKEW(4), .MAC_LAT(1), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .arr_a(arr_a), .arr_b(arr_b), .mac_clr(mac_clr),
      .res_in(res_in), .res_out(res_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .last_cycles(last_cycles)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_no = 0;
   int start_edge = 0;
   exp_t q[$];
   logic [95:0] ga [16];
   logic [95:0] gb [16];

   always @(posedge clk) edge_no <= edge_no + 1;

   // Array model: MAC(i,j) sees operands i+j cycles late and accumulates on the next edge.
   logic [95:0] a_h [0:4];
   logic [95:0] b_h [0:4];
   logic [63:0] acc [9];
   logic [95:0] av, bv;
   logic [63:0] prod;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (i + j == 0) begin
               av = arr_a;
               bv = arr_b;
            end else begin
               av = a_h[i+j];
               bv = b_h[i+j];
            end
            prod = 64'(get_lane(av, i)) * 64'(get_lane(bv, j));
            acc[i*3+j] <= mac_clr ? 64'd0 : acc[i*3+j] + prod;
         end
      end
      a_h[1] <= arr_a;
      b_h[1] <= arr_b;
      for (int k = 2; k < 5; k++) begin
         a_h[k] <= a_h[k-1];
         b_h[k] <= b_h[k-1];
      end
   end

   always_comb begin
      res_in = '0;
      for (int e = 0; e < 9; e++) res_in[64*e +: 64] = acc[e];
   end

   task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [575:0] pack9(input res9_t r);
      logic [575:0] v;
      v = '0;
      for (int e = 0; e < 9; e++) v[64*e +: 64] = r[e];
      return v;
   endfunction

   // Monitor: pops one expectation per out_valid rise, then watches res_out stay stable.
   logic         prev_v = 1'b0;
   logic [575:0] held = '0;
   always @(negedge clk) begin
      if (out_valid && !prev_v) begin
         if (q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("res_out", res_out, e.res);
            check("last_cycles", 576'(last_cycles), 576'(e.cyc));
            check("latency", 576'(edge_no - start_edge), 576'(e.cyc));
         end
         held = res_out;
      end else if (out_valid) begin
         check("res_out_stable", res_out, held);
      end
      prev_v = out_valid;
   end

   task automatic run_job(input logic [KW-1:0] k, input logic [15:0] vmask, input int hold,
                          input bit pulse_start, input bit early_ready, input res9_t er,
                          input logic [31:0] ecyc);
      exp_t e;
      int idx, p, guard, rdy_cnt;
      e.res = pack9(er);
      e.cyc = ecyc;
      q.push_back(e);
      @(negedge clk);
      k_len = k;
      start = 1'b1;
      out_ready = early_ready;
      start_edge = edge_no + 1;
      @(negedge clk);
      start = 1'b0;
      idx = 0; p = 0; guard = 0; rdy_cnt = 0;
      while (idx < int'(k) && guard < 400) begin
         if (in_ready) begin
            rdy_cnt++;
            in_valid = vmask[p % 16];
            if (vmask[p % 16]) begin
               in_a = ga[idx];
               in_b = gb[idx];
               idx++;
            end
            p++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0;
      check("beats_fed", 576'(idx), 576'(k));
      guard = 0;
      while (!out_valid && guard < 100) begin
         if (in_ready) rdy_cnt++;
         @(negedge clk);
         guard++;
      end
      check("out_valid_seen", 576'(out_valid), 576'(1));
      if (k == '0) check("in_ready_k0", 576'(rdy_cnt), 576'(0));
      repeat (hold) begin
         start = pulse_start;
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("released", 576'({out_valid, busy}), 576'(0));
   endtask

   res9_t er;
   logic [95:0] ones;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
      out_ready = 1'b0;
      ones = {3{32'hFFFF_FFFF}};
      #1;
      check("reset_ctrl", 576'({busy, in_ready, out_valid, mac_clr}), 576'(0));
      check("reset_data", {arr_a, arr_b, last_cycles}, 576'(0));
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // K=1, a=(1,2,3), b=(4,5,6)
      ga[0] = {32'd3, 32'd2, 32'd1};
      gb[0] = {32'd6, 32'd5, 32'd4};
      er = '{64'd4, 64'd5, 64'd6, 64'd8, 64'd10, 64'd12, 64'd12, 64'd15, 64'd18};
      run_job(16'd1, 16'hFFFF, 2, 1'b0, 1'b0, er, 32'd8);

      // K=3, identity A times B, no stalls then with 1,0,1,0,1 valid pattern
      ga[0] = {32'd0, 32'd0, 32'd1}; gb[0] = {32'd3, 32'd2, 32'd1};
      ga[1] = {32'd0, 32'd1, 32'd0}; gb[1] = {32'd6, 32'd5, 32'd4};
      ga[2] = {32'd1, 32'd0, 32'd0}; gb[2] = {32'd9, 32'd8, 32'd7};
      er = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'd9};
      run_job(16'd3, 16'hFFFF, 1, 1'b0, 1'b0, er, 32'd10);
      run_job(16'd3, 16'h0015, 1, 1'b0, 1'b0, er, 32'd12);

      // k_len = 0
      er = '{default: 64'd0};
      run_job(16'd0, 16'hFFFF, 1, 1'b0, 1'b0, er, 32'd7);

      // Held 5 cycles with start pulses in HOLD, then an all-ones job back to back
      ga[0] = {32'd3, 32'd2, 32'd1};
      gb[0] = {32'd6, 32'd5, 32'd4};
      er = '{64'd4, 64'd5, 64'd6, 64'd8, 64'd10, 64'd12, 64'd12, 64'd15, 64'd18};
      run_job(16'd1, 16'hFFFF, 5, 1'b1, 1'b0, er, 32'd8);
      ga[0] = ones; gb[0] = ones;
      er = '{default: 64'hFFFF_FFFE_0000_0001};
      run_job(16'd1, 16'hFFFF, 0, 1'b0, 1'b0, er, 32'd8);

      // Async reset after 2 of 4 beats
      for (int b = 0; b < 4; b++) begin
         ga[b] = {3{32'd100}};
         gb[b] = {3{32'd100}};
      end
      @(negedge clk);
      k_len = 16'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_a = ga[0]; in_b = gb[0];
      @(negedge clk);
      in_a = ga[1]; in_b = gb[1];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("mid_feed_busy_ready", 576'({busy, in_ready}), 576'(2'b11));
      #1;
      rst = 1'b1;
      #1;
      check("rst_ctrl", 576'({busy, in_ready, out_valid, mac_clr}), 576'(0));
      check("rst_arr", {arr_a, arr_b}, 576'(0));
      check("rst_res_out", res_out, 576'(0));
      check("rst_last_cycles", 576'(last_cycles), 576'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // K=1 after the aborted job: a=(2,3,4), b=(5,6,7)
      ga[0] = {32'd4, 32'd3, 32'd2};
      gb[0] = {32'd7, 32'd6, 32'd5};
      er = '{64'd10, 64'd12, 64'd14, 64'd15, 64'd18, 64'd21, 64'd20, 64'd24, 64'd28};
      run_job(16'd1, 16'hFFFF, 1, 1'b0, 1'b0, er, 32'd8);

      // Wrap: K=2, a_0=b_0=0xFFFFFFFF on both beats, out_ready high throughout
      for (int b = 0; b < 2; b++) begin
         ga[b] = {32'd0, 32'd0, 32'hFFFF_FFFF};
         gb[b] = {32'd0, 32'd0, 32'hFFFF_FFFF};
      end
      er = '{default: 64'd0};
      er[0] = 64'hFFFF_FFFC_0000_0002;
      run_job(16'd2, 16'hFFFF, 0, 1'b0, 1'b1, er, 32'd9);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 576'(q.size()), 576'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
